// File: rtl/mem_read_ctrl_pkg.sv
// mem_read_ctrl shared definitions.
// State encodings, default widths and counter sizing.
package mem_read_ctrl_pkg;

    localparam int DEF_N       = 8;
    localparam int DEF_W       = 8;
    localparam int DEF_TIMEOUT = 15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Wide enough to hold TIMEOUT-1 with one spare bit.
    function automatic int cnt_width(input int t);
        return $clog2(t) + 1;
    endfunction

endpackage

// File: rtl/mem_read_ctrl_if.sv
// mem_read_ctrl bus bundle.
// Control-unit request side plus memory read port.
interface mem_read_ctrl_if
    import mem_read_ctrl_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
);

    logic         req;
    logic [N-1:0] addr;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] data_out;
    logic         mem_rd;
    logic [N-1:0] mem_addr;
    logic [W-1:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output req,
        output addr,
        output mem_rdata,
        output mem_ready,
        input  busy,
        input  done,
        input  err,
        input  data_out,
        input  mem_rd,
        input  mem_addr
    );

    modport slave (
        input  req,
        input  addr,
        input  mem_rdata,
        input  mem_ready,
        output busy,
        output done,
        output err,
        output data_out,
        output mem_rd,
        output mem_addr
    );

endinterface

// File: rtl/mem_read_ctrl_mdr_reg.sv
// Memory data register.
// Loadable, async active-low clear.
module mdr_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture on load, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_read_ctrl.sv
// Memory read controller.
// Single-beat read with bounded wait on mem_ready.
module mem_read_ctrl
    import mem_read_ctrl_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic clk,
    input logic rst,
    mem_read_ctrl_if.slave bus
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  addr_q;
    logic          err_q;
    logic          in_idle;
    logic          in_read;
    logic          start;
    logic          expire;
    logic          rd_exit;
    logic [W-1:0]  ld_data;
    logic [W-1:0]  mdr_q;

    assign in_idle = (state == ST_IDLE);
    assign in_read = (state == ST_READ);
    assign start   = in_idle && bus.req;
    assign expire  = (cnt == LAST);
    // A response on the last allowed cycle still wins.
    assign rd_exit = in_read && (bus.mem_ready || expire);
    assign ld_data = bus.mem_ready ? bus.mem_rdata : '0;

    // Sequencing: IDLE -> READ -> DONE -> IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (bus.req) state <= ST_READ;
                ST_READ: if (rd_exit) state <= ST_DONE;
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Wait counter, stops at exit so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (in_read && !rd_exit) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Address latch, fixed for the whole transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
        end else if (start) begin
            addr_q <= bus.addr;
        end
    end

    // Error flag, updated only when READ exits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (rd_exit) begin
            err_q <= !bus.mem_ready;
        end
    end

    mdr_reg #(
        .W(W)
    ) u_mdr (
        .clk(clk),
        .rst(rst),
        .ld (rd_exit),
        .d  (ld_data),
        .q  (mdr_q)
    );

    assign bus.busy     = !in_idle;
    assign bus.done     = (state == ST_DONE);
    assign bus.mem_rd   = in_read;
    assign bus.mem_addr = addr_q;
    assign bus.err      = err_q;
    assign bus.data_out = mdr_q;

endmodule

// File: tb/tb_mem_read_ctrl.sv
// Directed bench for mem_read_ctrl.
// Drives and samples on the falling edge.
module tb_mem_read_ctrl;

    logic clk;
    logic rst;
    int   vecs;
    int   miss;

    mem_read_ctrl_if #(.N(8), .W(8)) bus ();

    mem_read_ctrl #(
        .N(8),
        .W(8),
        .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] memv(input logic [7:0] a);
        return {a[3:0], ~a[3:0]};
    endfunction

    // Starts a read at a negedge, returns at the negedge of done.
    // waits < 0: memory never answers.
    task automatic do_read(input logic [7:0] a, input int waits,
                           input logic [7:0] rd, output int lat,
                           output logic aok);
        int rc;
        rc  = 0;
        aok = 1'b1;
        bus.addr      = a;
        bus.req       = 1'b1;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            if (bus.mem_rd) begin
                rc++;
                if (bus.mem_addr !== a) aok = 1'b0;
                bus.mem_ready = (waits >= 0) && (rc > waits);
                bus.mem_rdata = rd;
                bus.addr      = ~a;
            end
            @(posedge clk);
            @(negedge clk);
            bus.mem_ready = 1'b0;
            lat++;
        end
        if (lat >= 40) chk("done_bound", 32'(lat), 32'd0);
    endtask

    initial begin
        int         lat;
        logic       aok;
        int         nd;
        int         last;
        vecs = 0;
        miss = 0;
        rst  = 1'b0;
        bus.req       = 1'b0;
        bus.addr      = 8'h00;
        bus.mem_rdata = 8'h00;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  32'(bus.busy),     32'd0);
        chk("rst_mrd",   32'(bus.mem_rd),   32'd0);
        chk("rst_maddr", 32'(bus.mem_addr), 32'd0);
        chk("rst_data",  32'(bus.data_out), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_read(8'h3C, 0, 8'hA5, lat, aok);
        chk("zw_lat",  32'(lat),          32'd2);
        chk("zw_addr", 32'(aok),          32'd1);
        chk("zw_data", 32'(bus.data_out), 32'hA5);
        chk("zw_err",  32'(bus.err),      32'd0);
        chk("zw_mrd",  32'(bus.mem_rd),   32'd0);
        @(negedge clk);
        chk("zw_pulse", 32'(bus.done),     32'd0);
        chk("zw_idle",  32'(bus.busy),     32'd0);
        chk("zw_hold",  32'(bus.data_out), 32'hA5);

        do_read(8'h77, 4, 8'h5A, lat, aok);
        chk("ws_lat",   32'(lat),          32'd6);
        chk("ws_addr",  32'(aok),          32'd1);
        chk("ws_maddr", 32'(bus.mem_addr), 32'h77);
        chk("ws_data",  32'(bus.data_out), 32'h5A);
        chk("ws_err",   32'(bus.err),      32'd0);
        @(negedge clk);

        do_read(8'h42, -1, 8'hFF, lat, aok);
        chk("to_lat",  32'(lat),          32'd16);
        chk("to_err",  32'(bus.err),      32'd1);
        chk("to_data", 32'(bus.data_out), 32'd0);
        chk("to_busy", 32'(bus.busy),     32'd1);
        @(negedge clk);
        chk("to_mrd",  32'(bus.mem_rd),   32'd0);
        chk("to_idle", 32'(bus.busy),     32'd0);
        chk("to_hold", 32'(bus.err),      32'd1);

        do_read(8'h99, 14, 8'hC3, lat, aok);
        chk("bd_lat",  32'(lat),          32'd16);
        chk("bd_err",  32'(bus.err),      32'd0);
        chk("bd_data", 32'(bus.data_out), 32'hC3);
        @(negedge clk);

        nd   = 0;
        last = -1;
        bus.addr      = 8'd1;
        bus.req       = 1'b1;
        bus.mem_ready = 1'b1;
        for (int c = 0; c < 14 && nd < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.mem_rdata = memv(bus.mem_addr);
            if (bus.done) begin
                chk("b2b_data", 32'(bus.data_out), 32'(memv(8'(nd + 1))));
                chk("b2b_err",  32'(bus.err),      32'd0);
                if (nd == 0) chk("b2b_first", 32'(c), 32'd1);
                else chk("b2b_gap", 32'(c - last), 32'd3);
                last = c;
                nd++;
                bus.addr = 8'(nd + 1);
                if (nd == 3) bus.req = 1'b0;
            end
        end
        bus.req       = 1'b0;
        bus.mem_ready = 1'b0;
        chk("b2b_count", 32'(nd), 32'd3);
        repeat (2) @(negedge clk);

        bus.addr = 8'h55;
        bus.req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        chk("mid_mrd", 32'(bus.mem_rd), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_mrd",  32'(bus.mem_rd),   32'd0);
        chk("ar_busy", 32'(bus.busy),     32'd0);
        chk("ar_done", 32'(bus.done),     32'd0);
        chk("ar_err",  32'(bus.err),      32'd0);
        chk("ar_data", 32'(bus.data_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ar_idle", 32'(bus.busy),   32'd0);
        chk("ar_mrd2", 32'(bus.mem_rd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
